mm_line_requester: RTL and testbench
====================================

Name: mm_line_requester

Overview:
- Requester (initiator) side of the main-memory port used by the L2 cache; main memory is the responder.
- Converts one 64-byte line request (refill read or writeback) into four 128-bit beat requests on the mm port.
- For reads, collects the four beat responses by address and returns one assembled 512-bit line to L2.
- One line in flight at a time; intended as one instance per mm port connected to L2.

Parameters:
- PADDR_WIDTH, 64, physical address width.
- TAG_WIDTH, 6, L2 transaction tag width.
- MM_ID_WIDTH, 8, mm port ID width. Must be >= TAG_WIDTH+2.
- TIMEOUT_CYCLES, 1024, maximum WAIT-state cycles before the line is aborted.

Ports:
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- line_req_valid  in  1  L2 line request valid
- line_req_ready  out  1  block can accept a line request
- line_req_is_write  in  1  1 = writeback, 0 = refill
- line_req_paddr  in  PADDR_WIDTH  line address; bits [5:0] ignored
- line_req_data  in  512  writeback data; beat k = [128k+:128]
- line_req_tag  in  TAG_WIDTH  L2 tag
- line_res_valid  out  1  one-cycle completion pulse
- line_res_is_write  out  1  completion belongs to a writeback
- line_res_error  out  1  line was aborted by timeout
- line_res_tag  out  TAG_WIDTH  tag of the completed line
- line_res_paddr  out  PADDR_WIDTH  line address with [5:0]=0
- line_res_data  out  512  assembled read data; 0 for writes
- mm_req_valid  out  1  beat request valid
- mm_req_is_write  out  1  beat is a write
- mm_req_id  out  MM_ID_WIDTH  {zero pad, tag, beat[1:0]}
- mm_req_paddr  out  PADDR_WIDTH  line base + 16*beat; bits [3:0]=0
- mm_req_data  out  128  write beat data
- mm_ready  in  1  memory accepts the beat this cycle
- mm_res_valid  in  1  read beat response valid
- mm_res_id  in  MM_ID_WIDTH  response ID
- mm_res_paddr  in  PADDR_WIDTH  response address
- mm_res_data  in  128  response data
- err_unexpected_res  out  1  sticky flag: stray or duplicate response

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, DONE.
- Reset: asynchronous; state goes to IDLE and every register, output and flag goes to 0. Any line in flight is abandoned and not reported. line_req_ready is 1 from the first cycle after reset deassertion.
- IDLE:
  - line_req_ready = 1 only in this state.
  - On line_req_valid, latch is_write, paddr (with [5:0] cleared), tag and data. Clear the beat counter, receive mask, data buffer and timeout counter. Go to ISSUE.
- ISSUE:
  - mm_req_valid = 1 with beat index b = 0..3, issued in ascending order.
  - mm_req_* outputs are held stable until mm_ready is sampled high.
  - On acceptance of beat 3: a write goes to DONE; a read goes to WAIT, or straight to DONE if the receive mask is already full.
- Read collection (active in ISSUE and WAIT):
  - A response matches when mm_res_valid=1, mm_res_id[TAG_WIDTH+1:2] equals the latched tag, and mm_res_paddr[PADDR_WIDTH-1:6] equals the latched line.
  - On a match, beat k = mm_res_paddr[5:4] is written to buf[128k+:128] and mask[k] is set. The paddr field, not the ID, selects the position.
  - Responses may arrive in any order, including in the same cycle as a later beat's issue.
  - A non-matching response, any response in IDLE or DONE, or a repeat of an already-set mask bit sets err_unexpected_res. A repeat still overwrites the buffer. err_unexpected_res clears only on reset.
- WAIT:
  - mm_req_valid = 0.
  - When the mask reaches 4'b1111, go to DONE.
  - The timeout counter increments each WAIT cycle. At TIMEOUT_CYCLES-1 go to DONE with line_res_error=1; line_res_data then holds whatever beats were received, missing beats 0.
- DONE:
  - line_res_valid = 1 for exactly one cycle, with no backpressure, carrying the latched tag, paddr, is_write and the buffer.
  - Next state is IDLE.
  - line_res_* outputs are 0 whenever line_res_valid = 0.
- Writes: memory returns no write response, so a write completes when beat 3 is accepted.
- Latency with mm_ready=1 and memory responding 1 cycle after acceptance:
  - line request accepted at edge T.
  - Beats issued in cycles T+1..T+4.
  - Write: line_res_valid in cycle T+5.
  - Read: responses in cycles T+2..T+5; line_res_valid in cycle T+6.
  - The next line_req is accepted in the IDLE cycle that follows the DONE cycle.
- Arithmetic:
  - Beat address = line base + {b, 4'b0}; no carry out of bit 5.
  - mm_req_id upper bits above TAG_WIDTH+2 are 0.

Test Plan:
- Read at paddr 0x8000_0040, tag 5, mm_ready=1, memory returns beats 0x11..,0x22..,0x33..,0x44.. -> mm_req_paddr 0x8000_0040/50/60/70 with ids 0x14..0x17; line_res_valid at T+6 with data {0x44..,0x33..,0x22..,0x11..}, tag 5.
- Writeback to 0x8000_0100 with data beats A,B,C,D, mm_ready low for 3 cycles during beat 1 -> beat 1 outputs held for 3 cycles; each beat issued exactly once; line_res_valid with is_write=1 in cycle T+8; line_res_data=0.
- Read with responses returned in order 3,1,0,2 -> data assembled in correct positions; no error flag.
- Read where beat 2 never returns, TIMEOUT_CYCLES=16 -> line_res_valid with line_res_error=1 after 16 WAIT cycles; beat 2 slice = 0.
- Stray response (wrong tag) during WAIT, plus a duplicate of beat 0 -> err_unexpected_res=1 and stays 1; the line still completes normally.
- Reset asserted during ISSUE at beat 2 -> all outputs 0 immediately; line_req_ready=1 after deassertion; no line_res_valid for the aborted line.

Source files
------------

// File: rtl/mm_line_requester_if.sv
// Main-memory port bundle between a line requester (master) and memory (slave).
// The requester issues 128-bit beat requests; memory returns read beats tagged by ID and address.
interface mm_line_requester_if #(
  parameter int PADDR_WIDTH = 64,
  parameter int MM_ID_WIDTH = 8
);
  logic                   mm_req_valid;
  logic                   mm_req_is_write;
  logic [MM_ID_WIDTH-1:0] mm_req_id;
  logic [PADDR_WIDTH-1:0] mm_req_paddr;
  logic [127:0]           mm_req_data;
  logic                   mm_ready;
  logic                   mm_res_valid;
  logic [MM_ID_WIDTH-1:0] mm_res_id;
  logic [PADDR_WIDTH-1:0] mm_res_paddr;
  logic [127:0]           mm_res_data;

  modport master (
    output mm_req_valid, mm_req_is_write, mm_req_id, mm_req_paddr, mm_req_data,
    input  mm_ready, mm_res_valid, mm_res_id, mm_res_paddr, mm_res_data
  );

  modport slave (
    input  mm_req_valid, mm_req_is_write, mm_req_id, mm_req_paddr, mm_req_data,
    output mm_ready, mm_res_valid, mm_res_id, mm_res_paddr, mm_res_data
  );
endinterface

// File: rtl/mm_line_requester.sv
// L2-side main-memory requester: splits one 64-byte line into four 128-bit beats,
// collects read beats by address (any order), and reports one completion per line.
// All outputs are registered from the next-state values so they are 0 during reset.
module mm_line_requester #(
  parameter int PADDR_WIDTH    = 64,
  parameter int TAG_WIDTH      = 6,
  parameter int MM_ID_WIDTH    = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   line_req_valid,
  output logic                   line_req_ready,
  input  logic                   line_req_is_write,
  input  logic [PADDR_WIDTH-1:0] line_req_paddr,
  input  logic [511:0]           line_req_data,
  input  logic [TAG_WIDTH-1:0]   line_req_tag,
  output logic                   line_res_valid,
  output logic                   line_res_is_write,
  output logic                   line_res_error,
  output logic [TAG_WIDTH-1:0]   line_res_tag,
  output logic [PADDR_WIDTH-1:0] line_res_paddr,
  output logic [511:0]           line_res_data,
  mm_line_requester_if.master    mm,
  output logic                   err_unexpected_res
);
  localparam int CNT_WIDTH  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LINE_WIDTH = PADDR_WIDTH - 6;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t                 state_r, state_s;
  logic                   is_write_r, is_write_s;
  logic [LINE_WIDTH-1:0]  line_r, line_s;
  logic [TAG_WIDTH-1:0]   tag_r, tag_s;
  logic [511:0]           wdata_r, wdata_s;
  logic [1:0]             beat_r, beat_s;
  logic [3:0]             mask_r, mask_s;
  logic [511:0]           rbuf_r, rbuf_s;
  logic [CNT_WIDTH-1:0]   tmo_r, tmo_s;
  logic                   timeout_s;

  logic                   collecting_s, match_s, unexpected_s, unused_s;
  logic [1:0]             res_beat_s;

  logic                   req_ready_r, req_ready_s;
  logic                   mm_req_valid_r, mm_req_valid_s;
  logic                   mm_req_is_write_r, mm_req_is_write_s;
  logic [MM_ID_WIDTH-1:0] mm_req_id_r, mm_req_id_s;
  logic [PADDR_WIDTH-1:0] mm_req_paddr_r, mm_req_paddr_s;
  logic [127:0]           mm_req_data_r, mm_req_data_s;
  logic                   res_valid_r, res_valid_s;
  logic                   res_is_write_r, res_is_write_s;
  logic                   res_error_r, res_error_s;
  logic [TAG_WIDTH-1:0]   res_tag_r, res_tag_s;
  logic [PADDR_WIDTH-1:0] res_paddr_r, res_paddr_s;
  logic [511:0]           res_data_r, res_data_s;
  logic                   err_r, err_s;

  // A response belongs to this line when tag and line address both match; the
  // beat slot comes from the address, not the ID, so reordered IDs still land right.
  assign collecting_s = (state_r == ISSUE) || (state_r == WAIT);
  assign res_beat_s   = mm.mm_res_paddr[5:4];
  assign match_s      = mm.mm_res_valid && collecting_s &&
                        (mm.mm_res_id[TAG_WIDTH+1:2] == tag_r) &&
                        (mm.mm_res_paddr[PADDR_WIDTH-1:6] == line_r);
  assign unexpected_s = mm.mm_res_valid && (!match_s || mask_r[res_beat_s]);
  assign unused_s     = ^{line_req_paddr[5:0], mm.mm_res_id, mm.mm_res_paddr[3:0]};

  // Next-state logic: line capture, beat sequencing, read collection and timeout.
  always_comb begin
    state_s    = state_r;
    is_write_s = is_write_r;
    line_s     = line_r;
    tag_s      = tag_r;
    wdata_s    = wdata_r;
    beat_s     = beat_r;
    mask_s     = mask_r;
    rbuf_s     = rbuf_r;
    tmo_s      = tmo_r;
    timeout_s  = 1'b0;
    if (match_s) begin
      mask_s[res_beat_s]                  = 1'b1;
      rbuf_s[{res_beat_s, 7'd0} +: 128]   = mm.mm_res_data;
    end else begin
      mask_s = mask_r;
    end
    case (state_r)
      IDLE: begin
        if (line_req_valid) begin
          is_write_s = line_req_is_write;
          line_s     = line_req_paddr[PADDR_WIDTH-1:6];
          tag_s      = line_req_tag;
          wdata_s    = line_req_data;
          beat_s     = 2'd0;
          mask_s     = 4'b0000;
          rbuf_s     = {512{1'b0}};
          tmo_s      = {CNT_WIDTH{1'b0}};
          state_s    = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (mm.mm_ready) begin
          if (beat_r == 2'd3) begin
            if (is_write_r || (mask_s == 4'b1111)) begin
              state_s = DONE;
            end else begin
              state_s = WAIT;
            end
          end else begin
            beat_s = beat_r + 2'd1;
          end
        end else begin
          state_s = ISSUE;
        end
      end
      WAIT: begin
        if (mask_s == 4'b1111) begin
          state_s = DONE;
        end else if (tmo_r == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          state_s   = DONE;
          timeout_s = 1'b1;
        end else begin
          tmo_s = tmo_r + CNT_WIDTH'(1);
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    req_ready_s       = (state_s == IDLE);
    mm_req_valid_s    = 1'b0;
    mm_req_is_write_s = 1'b0;
    mm_req_id_s       = {MM_ID_WIDTH{1'b0}};
    mm_req_paddr_s    = {PADDR_WIDTH{1'b0}};
    mm_req_data_s     = 128'd0;
    res_valid_s       = 1'b0;
    res_is_write_s    = 1'b0;
    res_error_s       = 1'b0;
    res_tag_s         = {TAG_WIDTH{1'b0}};
    res_paddr_s       = {PADDR_WIDTH{1'b0}};
    res_data_s        = {512{1'b0}};
    err_s             = err_r | unexpected_s;
    if (state_s == ISSUE) begin
      mm_req_valid_s    = 1'b1;
      mm_req_is_write_s = is_write_s;
      mm_req_id_s       = MM_ID_WIDTH'({tag_s, beat_s});
      mm_req_paddr_s    = {line_s, beat_s, 4'b0000};
      mm_req_data_s     = is_write_s ? wdata_s[{beat_s, 7'd0} +: 128] : 128'd0;
    end else begin
      mm_req_valid_s = 1'b0;
    end
    if (state_s == DONE) begin
      res_valid_s    = 1'b1;
      res_is_write_s = is_write_s;
      res_error_s    = timeout_s;
      res_tag_s      = tag_s;
      res_paddr_s    = {line_s, 6'b000000};
      res_data_s     = is_write_s ? {512{1'b0}} : rbuf_s;
    end else begin
      res_valid_s = 1'b0;
    end
  end

  // State, line context and output registers; reset abandons any line in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r           <= IDLE;
      is_write_r        <= 1'b0;
      line_r            <= {LINE_WIDTH{1'b0}};
      tag_r             <= {TAG_WIDTH{1'b0}};
      wdata_r           <= {512{1'b0}};
      beat_r            <= 2'd0;
      mask_r            <= 4'b0000;
      rbuf_r            <= {512{1'b0}};
      tmo_r             <= {CNT_WIDTH{1'b0}};
      req_ready_r       <= 1'b0;
      mm_req_valid_r    <= 1'b0;
      mm_req_is_write_r <= 1'b0;
      mm_req_id_r       <= {MM_ID_WIDTH{1'b0}};
      mm_req_paddr_r    <= {PADDR_WIDTH{1'b0}};
      mm_req_data_r     <= 128'd0;
      res_valid_r       <= 1'b0;
      res_is_write_r    <= 1'b0;
      res_error_r       <= 1'b0;
      res_tag_r         <= {TAG_WIDTH{1'b0}};
      res_paddr_r       <= {PADDR_WIDTH{1'b0}};
      res_data_r        <= {512{1'b0}};
      err_r             <= 1'b0;
    end else begin
      state_r           <= state_s;
      is_write_r        <= is_write_s;
      line_r            <= line_s;
      tag_r             <= tag_s;
      wdata_r           <= wdata_s;
      beat_r            <= beat_s;
      mask_r            <= mask_s;
      rbuf_r            <= rbuf_s;
      tmo_r             <= tmo_s;
      req_ready_r       <= req_ready_s;
      mm_req_valid_r    <= mm_req_valid_s;
      mm_req_is_write_r <= mm_req_is_write_s;
      mm_req_id_r       <= mm_req_id_s;
      mm_req_paddr_r    <= mm_req_paddr_s;
      mm_req_data_r     <= mm_req_data_s;
      res_valid_r       <= res_valid_s;
      res_is_write_r    <= res_is_write_s;
      res_error_r       <= res_error_s;
      res_tag_r         <= res_tag_s;
      res_paddr_r       <= res_paddr_s;
      res_data_r        <= res_data_s;
      err_r             <= err_s;
    end
  end

  assign line_req_ready     = req_ready_r;
  assign mm.mm_req_valid    = mm_req_valid_r;
  assign mm.mm_req_is_write = mm_req_is_write_r;
  assign mm.mm_req_id       = mm_req_id_r;
  assign mm.mm_req_paddr    = mm_req_paddr_r;
  assign mm.mm_req_data     = mm_req_data_r;
  assign line_res_valid     = res_valid_r;
  assign line_res_is_write  = res_is_write_r;
  assign line_res_error     = res_error_r;
  assign line_res_tag       = res_tag_r;
  assign line_res_paddr     = res_paddr_r;
  assign line_res_data      = res_data_r;
  assign err_unexpected_res = err_r;
endmodule

// File: tb/tb_mm_line_requester.sv
// Directed and randomized bench for mm_line_requester with a behavioural memory model.
module tb_mm_line_requester;
  localparam int PW = 64;
  localparam int TW = 6;
  localparam int IW = 8;
  localparam int TO = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          line_req_valid, line_req_ready, line_req_is_write;
  logic [PW-1:0] line_req_paddr;
  logic [511:0]  line_req_data;
  logic [TW-1:0] line_req_tag;
  logic          line_res_valid, line_res_is_write, line_res_error;
  logic [TW-1:0] line_res_tag;
  logic [PW-1:0] line_res_paddr;
  logic [511:0]  line_res_data;
  logic          err_unexpected_res;

  mm_line_requester_if #(.PADDR_WIDTH(PW), .MM_ID_WIDTH(IW)) mif ();

  mm_line_requester #(.PADDR_WIDTH(PW), .TAG_WIDTH(TW), .MM_ID_WIDTH(IW), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .line_req_valid(line_req_valid), .line_req_ready(line_req_ready),
    .line_req_is_write(line_req_is_write), .line_req_paddr(line_req_paddr),
    .line_req_data(line_req_data), .line_req_tag(line_req_tag),
    .line_res_valid(line_res_valid), .line_res_is_write(line_res_is_write),
    .line_res_error(line_res_error), .line_res_tag(line_res_tag),
    .line_res_paddr(line_res_paddr), .line_res_data(line_res_data),
    .mm(mif), .err_unexpected_res(err_unexpected_res)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit err_exp = 1'b0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic clear_mm();
    mif.mm_ready = 1'b0;
    mif.mm_res_valid = 1'b0;
    mif.mm_res_id = '0;
    mif.mm_res_paddr = '0;
    mif.mm_res_data = '0;
  endtask

  // One line transaction. mode 0: memory answers each accepted read beat one cycle later.
  // mode 1: after all beats are accepted, answers in order ord[] (skipping drop), optionally
  // with a wrong-tag response and a duplicate of ord[0] inserted after the first answer.
  task automatic do_line(input bit wr, input logic [PW-1:0] pa, input logic [TW-1:0] tg,
                         input logic [511:0] wd, input logic [511:0] rd,
                         input int stall_beat, input int stall_n, input bit rand_ready,
                         input int mode, input int ord[4], input int drop, input bit inject,
                         input int exp_k, input int rst_beat);
    logic [127:0] mbuf[4];
    bit           got[4];
    int           acc, k, it, stall_left;
    int           sendq[$];
    int           imm_q[$];
    bit           done, built, rdy, all_got;
    logic [PW-1:0] base;
    logic [511:0] exp_data;
    logic [127:0] rdata;
    base = {pa[PW-1:6], 6'd0};
    for (int b = 0; b < 4; b++) begin mbuf[b] = '0; got[b] = 1'b0; end
    acc = 0; k = 0; done = 1'b0; built = 1'b0; stall_left = stall_n;
    chk("ready_before_req", 512'(line_req_ready), 512'(1'b1));
    line_req_valid = 1'b1; line_req_is_write = wr; line_req_paddr = pa;
    line_req_data = wd; line_req_tag = tg;
    tick();
    line_req_valid = 1'b0; line_req_data = rand512();
    line_req_paddr = {$urandom, $urandom}; line_req_tag = TW'($urandom);
    chk("ready_while_busy", 512'(line_req_ready), 512'(1'b0));
    while (!done && k < 100) begin
      chk("err_flag", 512'(err_unexpected_res), 512'(err_exp));
      if (rst_beat >= 0 && mif.mm_req_valid && acc == rst_beat) begin
        reset = 1'b1;
        #1;
        chk("rst_req_ready", 512'(line_req_ready), 512'(1'b0));
        chk("rst_mm_valid", 512'(mif.mm_req_valid), 512'(1'b0));
        chk("rst_mm_paddr", 512'(mif.mm_req_paddr), 512'(0));
        chk("rst_mm_id", 512'(mif.mm_req_id), 512'(0));
        chk("rst_res_valid", 512'(line_res_valid), 512'(1'b0));
        chk("rst_err", 512'(err_unexpected_res), 512'(1'b0));
        err_exp = 1'b0;
        clear_mm();
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("ready_after_reset", 512'(line_req_ready), 512'(1'b1));
        for (int c = 0; c < 8; c++) begin
          chk("no_res_after_abort", 512'(line_res_valid), 512'(1'b0));
          chk("no_beat_after_abort", 512'(mif.mm_req_valid), 512'(1'b0));
          tick();
        end
        return;
      end
      if (line_res_valid) begin
        done = 1'b1;
        all_got = got[0] && got[1] && got[2] && got[3];
        for (int b = 0; b < 4; b++) exp_data[128*b +: 128] = (!wr && got[b]) ? mbuf[b] : 128'd0;
        if (exp_k >= 0) chk("res_latency", 512'(k), 512'(exp_k));
        chk("res_is_write", 512'(line_res_is_write), 512'(wr));
        chk("res_tag", 512'(line_res_tag), 512'(tg));
        chk("res_paddr", 512'(line_res_paddr), 512'(base));
        chk("res_error", 512'(line_res_error), 512'(!wr && !all_got));
        chk("res_data", line_res_data, exp_data);
        chk("beats_at_done", 512'(acc), 512'(4));
        chk("no_beat_in_done", 512'(mif.mm_req_valid), 512'(1'b0));
        clear_mm();
      end else begin
        chk("res_data_quiet", line_res_data, 512'(0));
        if (mif.mm_req_valid) begin
          if (acc < 4) begin
            chk("beat_paddr", 512'(mif.mm_req_paddr), 512'(base + PW'(16 * acc)));
            chk("beat_id", 512'(mif.mm_req_id), 512'({tg, acc[1:0]}));
            chk("beat_is_write", 512'(mif.mm_req_is_write), 512'(wr));
            if (wr) chk("beat_wdata", 512'(mif.mm_req_data), 512'(wd[128*acc +: 128]));
          end else begin
            chk("beats_issued", 512'(acc + 1), 512'(4));
          end
        end
        // memory response for this cycle
        mif.mm_res_valid = 1'b0;
        it = -1;
        if (mode == 0 && imm_q.size() > 0) it = imm_q.pop_front();
        if (mode == 1 && sendq.size() > 0) it = sendq.pop_front();
        if (it >= 0) begin
          mif.mm_res_valid = 1'b1;
          if (it < 4) begin
            rdata = rd[128*it +: 128];
            if (got[it]) err_exp = 1'b1;
            mbuf[it] = rdata; got[it] = 1'b1;
            mif.mm_res_id = {tg, it[1:0]};
            mif.mm_res_paddr = base + PW'(16 * it) + PW'($urandom_range(0, 15));
          end else if (it == 4) begin
            rdata = rand512()[127:0];
            err_exp = 1'b1;
            mif.mm_res_id = {tg ^ 6'd1, 2'd0};
            mif.mm_res_paddr = base;
          end else begin
            rdata = rand512()[127:0];
            err_exp = 1'b1;
            mbuf[ord[0]] = rdata;
            mif.mm_res_id = {tg, 2'd0};
            mif.mm_res_paddr = base + PW'(16 * ord[0]);
          end
          mif.mm_res_data = rdata;
        end
        // memory ready for this cycle
        if (mif.mm_req_valid && acc < 4) begin
          if (stall_beat == acc && stall_left > 0) begin rdy = 1'b0; stall_left--; end
          else if (rand_ready) rdy = 1'($urandom_range(0, 1));
          else rdy = 1'b1;
        end else begin
          rdy = 1'($urandom_range(0, 1));
        end
        mif.mm_ready = rdy;
        if (mif.mm_req_valid && rdy) begin
          if (mode == 0 && !wr) imm_q.push_back(acc);
          acc++;
        end
        if (mode == 1 && !wr && acc == 4 && !built) begin
          built = 1'b1;
          for (int i = 0; i < 4; i++) begin
            if (ord[i] != drop) sendq.push_back(ord[i]);
            if (i == 0 && inject) begin sendq.push_back(4); sendq.push_back(5); end
          end
        end
        tick();
        k++;
      end
    end
    if (!done) chk("line_completes_in_budget", 512'(done), 512'(1'b1));
    clear_mm();
    tick();
    chk("res_single_cycle", 512'(line_res_valid), 512'(1'b0));
    chk("ready_after_done", 512'(line_req_ready), 512'(1'b1));
    chk("err_after_done", 512'(err_unexpected_res), 512'(err_exp));
  endtask

  initial begin
    int o_inc[4];
    int o_mix[4];
    int o_rnd[4];
    int j, t;
    bit rw;
    o_inc = '{0, 1, 2, 3};
    o_mix = '{3, 1, 0, 2};
    line_req_valid = 1'b0; line_req_is_write = 1'b0; line_req_paddr = '0;
    line_req_data = '0; line_req_tag = '0;
    clear_mm();
    tick(); tick();
    chk("reset_ready", 512'(line_req_ready), 512'(1'b0));
    chk("reset_mm_valid", 512'(mif.mm_req_valid), 512'(1'b0));
    chk("reset_res_valid", 512'(line_res_valid), 512'(1'b0));
    chk("reset_err", 512'(err_unexpected_res), 512'(1'b0));
    reset = 1'b0;
    tick();
    chk("ready_first_cycle", 512'(line_req_ready), 512'(1'b1));

    // in-order read, full-rate memory
    do_line(1'b0, 64'h8000_0040, 6'd5, rand512(),
            {{16{8'h44}}, {16{8'h33}}, {16{8'h22}}, {16{8'h11}}},
            -1, 0, 1'b0, 0, o_inc, -1, 1'b0, 5, -1);
    // writeback with beat 1 stalled three cycles
    do_line(1'b1, 64'h8000_0100, 6'd9, {{16{8'hDD}}, {16{8'hCC}}, {16{8'hBB}}, {16{8'hAA}}}, '0,
            1, 3, 1'b0, 0, o_inc, -1, 1'b0, 7, -1);
    // out-of-order read responses
    do_line(1'b0, 64'h0000_1234_5678_9AC0, 6'd33, '0, rand512(),
            -1, 0, 1'b0, 1, o_mix, -1, 1'b0, -1, -1);
    // beat 2 never returns: 16 WAIT cycles then error completion
    do_line(1'b0, 64'h0000_0000_0000_2000, 6'd12, '0, rand512(),
            -1, 0, 1'b0, 1, o_inc, 2, 1'b0, 20, -1);
    // stray tag plus duplicate beat 0 during WAIT
    do_line(1'b0, 64'h0000_0000_0040_0080, 6'd63, '0, rand512(),
            -1, 0, 1'b0, 1, o_inc, -1, 1'b1, -1, -1);
    // randomized lines
    for (int n = 0; n < 6; n++) begin
      o_rnd = '{0, 1, 2, 3};
      for (int i = 3; i > 0; i--) begin
        j = $urandom_range(0, i);
        t = o_rnd[i]; o_rnd[i] = o_rnd[j]; o_rnd[j] = t;
      end
      rw = 1'($urandom_range(0, 1));
      do_line(rw, {$urandom, $urandom}, TW'($urandom), rand512(), rand512(),
              -1, 0, 1'b1, $urandom_range(0, 1), o_rnd, -1, 1'b0, -1, -1);
    end
    // reset while beat 2 is presented
    do_line(1'b0, 64'h8000_0400, 6'd7, '0, rand512(),
            -1, 0, 1'b0, 0, o_inc, -1, 1'b0, -1, 2);
    // clean line after the abort
    do_line(1'b0, 64'h8000_0800, 6'd21, '0, rand512(),
            -1, 0, 1'b0, 0, o_inc, -1, 1'b0, 5, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
